// File: rtl/dna_seq_ctrl.sv
// Two-requester controller for the device DNA_PORT: reads the 57-bit ID twice,
// publishes it only when both passes agree, and retries a bounded number of times.
module dna_seq_ctrl #(
    parameter int CLK_DIV   = 4,
    parameter int MAX_RETRY = 3
) (
    input  logic        ip_sys_clk,
    input  logic        ip_sys_nrst,
    input  logic [1:0]  req,
    output logic [1:0]  ack,
    output logic        dna_clk,
    output logic        dna_read,
    output logic        dna_shift,
    output logic        dna_din,
    input  logic        dna_dout,
    output logic [56:0] dna_id,
    output logic        dna_rdy,
    output logic        dna_err,
    output logic        busy
);
    typedef enum logic [2:0] {BOOT, IDLE, LOAD, SHIFT, CHECK, DONE} state_t;

    state_t      state_q;
    logic [7:0]  div_q;
    logic [5:0]  bit_q;
    logic        pass_q;
    logic [56:0] shreg_q;
    logic [56:0] cap_a_q;
    logic [3:0]  retry_q;
    logic        rr_q;
    logic        gnt_q;
    logic        has_gnt_q;
    logic [1:0]  ack_q;
    logic        dna_clk_q, dna_read_q, dna_shift_q, dna_din_q;
    logic [56:0] dna_id_q;
    logic        dna_rdy_q, dna_err_q, busy_q;

    logic        tick;
    logic        rise;
    logic        fall;
    logic        gnt_sel;

    // The divider only runs while the DNA_PORT clock is in use, so dna_clk rests low elsewhere.
    assign tick    = (state_q == LOAD || state_q == SHIFT) && (div_q == 8'(CLK_DIV - 1));
    assign rise    = tick && !dna_clk_q;
    assign fall    = tick && dna_clk_q;
    assign gnt_sel = (req == 2'b11) ? rr_q : req[1];

    always_ff @(posedge ip_sys_clk) begin
        if (!ip_sys_nrst) begin
            state_q     <= BOOT;
            div_q       <= 8'd0;
            bit_q       <= 6'd0;
            pass_q      <= 1'b0;
            shreg_q     <= '0;
            cap_a_q     <= '0;
            retry_q     <= 4'd0;
            rr_q        <= 1'b0;
            gnt_q       <= 1'b0;
            has_gnt_q   <= 1'b0;
            ack_q       <= 2'b00;
            dna_clk_q   <= 1'b0;
            dna_read_q  <= 1'b0;
            dna_shift_q <= 1'b0;
            dna_din_q   <= 1'b0;
            dna_id_q    <= '0;
            dna_rdy_q   <= 1'b0;
            dna_err_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            ack_q     <= 2'b00;
            dna_din_q <= 1'b0;
            if (state_q == LOAD || state_q == SHIFT) begin
                div_q <= tick ? 8'd0 : div_q + 8'd1;
            end else begin
                div_q <= 8'd0;
            end
            if (tick) begin
                dna_clk_q <= ~dna_clk_q;
            end

            // READ/SHIFT only change on falling ticks so they are stable around every rise.
            case (state_q)
                BOOT: begin
                    has_gnt_q  <= 1'b0;
                    pass_q     <= 1'b0;
                    dna_read_q <= 1'b1;
                    busy_q     <= 1'b1;
                    state_q    <= LOAD;
                end
                IDLE: begin
                    if (req != 2'b00) begin
                        gnt_q      <= gnt_sel;
                        rr_q       <= ~gnt_sel;
                        has_gnt_q  <= 1'b1;
                        pass_q     <= 1'b0;
                        dna_read_q <= 1'b1;
                        busy_q     <= 1'b1;
                        state_q    <= LOAD;
                    end
                end
                LOAD: begin
                    if (fall) begin
                        dna_read_q  <= 1'b0;
                        dna_shift_q <= 1'b1;
                        bit_q       <= 6'd0;
                        state_q     <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (rise) begin
                        shreg_q <= {shreg_q[55:0], dna_dout};
                        bit_q   <= bit_q + 6'd1;
                    end
                    if (fall && bit_q == 6'd57) begin
                        dna_shift_q <= 1'b0;
                        if (!pass_q) begin
                            cap_a_q    <= shreg_q;
                            pass_q     <= 1'b1;
                            dna_read_q <= 1'b1;
                            state_q    <= LOAD;
                        end else begin
                            state_q <= CHECK;
                        end
                    end
                end
                CHECK: begin
                    if (shreg_q == cap_a_q) begin
                        dna_id_q  <= cap_a_q;
                        dna_rdy_q <= 1'b1;
                        dna_err_q <= 1'b0;
                        retry_q   <= 4'd0;
                        ack_q     <= has_gnt_q ? (gnt_q ? 2'b10 : 2'b01) : 2'b00;
                        state_q   <= DONE;
                    end else if (retry_q == 4'(MAX_RETRY - 1)) begin
                        dna_err_q <= 1'b1;
                        retry_q   <= 4'd0;
                        ack_q     <= has_gnt_q ? (gnt_q ? 2'b10 : 2'b01) : 2'b00;
                        state_q   <= DONE;
                    end else begin
                        retry_q    <= retry_q + 4'd1;
                        pass_q     <= 1'b0;
                        dna_read_q <= 1'b1;
                        state_q    <= LOAD;
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= BOOT;
            endcase
        end
    end

    assign ack       = ack_q;
    assign dna_clk   = dna_clk_q;
    assign dna_read  = dna_read_q;
    assign dna_shift = dna_shift_q;
    assign dna_din   = dna_din_q;
    assign dna_id    = dna_id_q;
    assign dna_rdy   = dna_rdy_q;
    assign dna_err   = dna_err_q;
    assign busy      = busy_q;
endmodule
